bit_flip_seq: RTL and testbench
===============================

# bit_flip_seq

Sequencer for the `changer` bit-toggle datapath. It loads an N-bit working word, then accepts a stream of bit indices over a valid/ready handshake. For each index it toggles one bit through `changer` and registers the result, and it closes the job on a `last` beat. Invalid indices are rejected and counted, never applied. It sits between a command source and any consumer of the finished word.

## Interface
- `N`, default 8: word width; also the width of each index beat, interpreted as sign + magnitude exactly as `changer` does.
- `CW`, default 8: width of the flip and error counters; both saturate at 2^CW−1.

- `i_clk`, input, 1: clock; all state changes on the rising edge.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_load`, input, 1: start job; sampled only in IDLE.
- `i_data`, input, N: initial working word, captured with `i_load`.
- `i_valid`, input, 1: index beat valid.
- `i_idx`, input, N: bit index; MSB is the sign; magnitude is `i_idx[N-2:0]`.
- `i_last`, input, 1: qualifies a beat as the final one of the job.
- `o_ready`, output, 1: sequencer accepts index beats; high only in RUN.
- `o_busy`, output, 1: high in RUN and DONE.
- `o_done`, output, 1: one-cycle pulse when the job completes.
- `o_result`, output, N: working word register.
- `o_ERR`, output, 1: sticky per job; at least one rejected index.
- `o_flips`, output, CW: count of applied toggles this job.
- `o_errs`, output, CW: count of rejected indices this job.

## Operation
- States are IDLE, RUN and DONE. The encoding is a typedef enum.
- **Reset:** state IDLE. `o_result`, `o_flips`, `o_errs` and `o_ERR` are 0. `o_ready`, `o_busy` and `o_done` are 0.
- **IDLE:**
  - `i_load`=1: `o_result`←`i_data`; `o_flips`, `o_errs` and `o_ERR` clear to 0; next state RUN.
  - Otherwise all registers hold, so the previous job's result stays readable.
- **RUN:** `o_ready`=1. A beat is accepted when `i_valid`=1, because ready is always high in RUN. `i_idx` drives `changer.i_b` and `o_result` drives `changer.i_a`.
  - Valid index (changer `o_ERR`=0): `o_result`←`changer.o_out`; `o_flips` increments (saturating).
  - Rejected index (changer `o_ERR`=1, i.e. sign set or magnitude ≥ N): `o_result` holds; `o_ERR`←1; `o_errs` increments (saturating).
  - Accepted beat with `i_last`=1: the beat is processed normally, then next state DONE.
  - `i_valid`=0: nothing changes, including `i_last`, which is ignored without valid.
  - `i_load` is ignored.
- **DONE:** lasts exactly one cycle. `o_done`=1 and `o_ready`=0. `i_load` and beats are ignored. Next state is IDLE unconditionally.
- **Arithmetic:**
  - Toggles are XOR, so repeating an index cancels the earlier toggle.
  - Counters never wrap; they stick at all-ones.
  - Indices are never truncated; validity is decided by `changer` only.
- **Reset mid-job:** reset in RUN or DONE forces IDLE and clears every output to its reset value. A partial job is discarded with no `o_done`.

## Timing
- `i_load` in IDLE at cycle t gives `o_ready`=1 and `o_busy`=1 at t+1.
- A beat accepted at cycle t is visible on `o_result`, counters and `o_ERR` at t+1. Sustained throughput is one index per cycle.
- A last beat at cycle t gives `o_done`=1 at t+1, with the final `o_result`, `o_ERR` and counters already valid that cycle. At t+2 the state is IDLE and `o_ready`=0.
- The earliest next `i_load` is accepted at t+2.
- `o_result`, `o_ERR` and the counters are stable from `o_done` until the next accepted `i_load`.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to `o_ready`, `o_busy` or `o_done`.

## Structure
- `bit_flip_pkg` holds the state enum typedef, the `N`/`CW` default constants, and the counter saturation helper function.
- The sub-module is one instance of `changer #(.N(N))`. Tie its `i_clk`/`i_rst` to the sequencer's clock and reset; its outputs feed the next-state logic directly.
- The target is one `always_ff` for the registers and one `always_comb` for next-state and `o_ready`/`o_busy`/`o_done` decode.

## Test plan
- **Basic job:** load 0x00, then beats 0 and 7 (last). Expect `o_result`=0x81, `o_flips`=2, `o_errs`=0, `o_ERR`=0, and `o_done` exactly one cycle after the last beat.
- **Rejected indices:** load 0x3C, then beats 8, 0x80 and 2 (last). Expect `o_result`=0x38, `o_errs`=2, `o_flips`=1, `o_ERR`=1.
- **Cancel and gaps:** load 0xA5, then beat 3, two idle cycles, beat 3 (last). Expect `o_result`=0xA5, `o_flips`=2, and no state change during the gaps.
- **Ignored inputs:** assert `i_load` with 0xFF during RUN and in the DONE cycle. Expect no effect. `i_last` without `i_valid` must not end the job.
- **Reset mid-job:** after load 0x0F and beat 4, assert `i_rst` in RUN. Expect IDLE next cycle, all outputs 0, and no `o_done`.
- **Saturation:** with `CW`=2, load 0x00 and send 5 valid beats. Expect `o_flips`=3 and `o_result` equal to the XOR of all five toggles.

Source files
------------

// File: rtl/bit_flip_pkg.sv
// Shared types, default widths and counter helper for the bit_flip_seq sequencer.
package bit_flip_pkg;

  localparam int unsigned N_DEF  = 8;
  localparam int unsigned CW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Increment that sticks at max; callers pass counters zero-extended to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
    return (val >= max) ? max : val + 32'd1;
  endfunction

endpackage

// File: rtl/bit_flip_seq_changer.sv
// changer: toggles bit |i_b| of i_a; flags sign-set or out-of-range indices.
module changer #(
  parameter int unsigned N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_out,
  output logic         o_ERR
);

  logic [N-1:0] mag;
  logic         unused_clk_rst;

  // Purely combinational; clock and reset are tied in for interface uniformity only.
  assign unused_clk_rst = i_clk ^ i_rst;

  always_comb begin
    mag   = {1'b0, i_b[N-2:0]};
    o_ERR = i_b[N-1] || (mag >= N'(N));
    o_out = i_a ^ (N'(1) << mag);
  end

endmodule

// File: rtl/bit_flip_seq.sv
// Job sequencer: loads a word, applies a stream of bit toggles via changer, closes on last.
module bit_flip_seq
  import bit_flip_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [N-1:0]  i_data,
  input  logic          i_valid,
  input  logic [N-1:0]  i_idx,
  input  logic          i_last,
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic [N-1:0]  o_result,
  output logic          o_ERR,
  output logic [CW-1:0] o_flips,
  output logic [CW-1:0] o_errs
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  state_e        state_q,  state_d;
  logic [N-1:0]  result_q, result_d;
  logic          err_q,    err_d;
  logic [CW-1:0] flips_q,  flips_d;
  logic [CW-1:0] errs_q,   errs_d;

  logic [N-1:0]  chg_out;
  logic          chg_err;

  changer #(.N(N)) u_changer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_a   (result_q),
    .i_b   (i_idx),
    .o_out (chg_out),
    .o_ERR (chg_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      err_q    <= 1'b0;
      flips_q  <= '0;
      errs_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
      flips_q  <= flips_d;
      errs_q   <= errs_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    err_d    = err_q;
    flips_d  = flips_q;
    errs_d   = errs_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_load) begin
          result_d = i_data;
          err_d    = 1'b0;
          flips_d  = '0;
          errs_d   = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_valid) begin
          if (chg_err) begin
            err_d  = 1'b1;
            errs_d = CW'(sat_inc(32'(errs_q), 32'(CNT_MAX)));
          end else begin
            result_d = chg_out;
            flips_d  = CW'(sat_inc(32'(flips_q), 32'(CNT_MAX)));
          end
          if (i_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake and status decoded from state only.
  always_comb begin
    o_ready = (state_q == ST_RUN);
    o_busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    o_done  = (state_q == ST_DONE);
  end

  assign o_result = result_q;
  assign o_ERR    = err_q;
  assign o_flips  = flips_q;
  assign o_errs   = errs_q;

endmodule

// File: tb/tb_bit_flip_seq.sv
// Directed self-checking bench for bit_flip_seq (CW=8 main instance, CW=2 saturation instance).
module tb_bit_flip_seq;

  logic       clk = 1'b0;
  logic       rst, load, valid, last;
  logic [7:0] data, idx;

  logic       ready, busy, done, err;
  logic [7:0] result, flips, errs;
  logic       s_ready, s_busy, s_done, s_err;
  logic [7:0] s_result;
  logic [1:0] s_flips, s_errs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_flip_seq #(.N(8), .CW(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_load(load), .i_data(data), .i_valid(valid),
    .i_idx(idx), .i_last(last), .o_ready(ready), .o_busy(busy), .o_done(done),
    .o_result(result), .o_ERR(err), .o_flips(flips), .o_errs(errs)
  );

  bit_flip_seq #(.N(8), .CW(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_load(load), .i_data(data), .i_valid(valid),
    .i_idx(idx), .i_last(last), .o_ready(s_ready), .o_busy(s_busy), .o_done(s_done),
    .o_result(s_result), .o_ERR(s_err), .o_flips(s_flips), .o_errs(s_errs)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d);
    load = 1'b1; data = d;
    tick();
    load = 1'b0; data = 8'h00;
  endtask

  task automatic beat(input logic [7:0] i, input logic l);
    valid = 1'b1; idx = i; last = l;
    tick();
    valid = 1'b0; idx = 8'h00; last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; data = 8'h00; valid = 1'b0; idx = 8'h00; last = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp 00", result); end
    checks++; if ({ready, busy, done, err} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {ready, busy, done, err}); end
    checks++; if ({flips, errs} !== 16'h0000) begin errors++; $display("FAIL reset_counters got %h exp 0000", {flips, errs}); end
  endtask

  task automatic test_basic();
    do_load(8'h00);
    checks++; if ({ready, busy, done} !== 3'b110) begin errors++; $display("FAIL basic_run_flags got %b exp 110", {ready, busy, done}); end
    beat(8'd0, 1'b0);
    checks++; if (result !== 8'h01 || flips !== 8'd1) begin errors++; $display("FAIL basic_first got %h/%0d exp 01/1", result, flips); end
    beat(8'd7, 1'b1);
    checks++; if (done !== 1'b1 || ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_done got d%b r%b b%b exp d1 r0 b1", done, ready, busy); end
    checks++; if (result !== 8'h81) begin errors++; $display("FAIL basic_result got %h exp 81", result); end
    checks++; if (flips !== 8'd2 || errs !== 8'd0 || err !== 1'b0) begin errors++; $display("FAIL basic_counts got f%0d e%0d E%b exp f2 e0 E0", flips, errs, err); end
    tick();
    checks++; if ({ready, busy, done} !== 3'b000 || result !== 8'h81) begin errors++; $display("FAIL basic_idle got %b/%h exp 000/81", {ready, busy, done}, result); end
  endtask

  task automatic test_rejected();
    do_load(8'h3C);
    beat(8'd8, 1'b0);
    checks++; if (result !== 8'h3C || err !== 1'b1 || errs !== 8'd1) begin errors++; $display("FAIL rej_mag got %h/E%b/%0d exp 3c/E1/1", result, err, errs); end
    beat(8'h80, 1'b0);
    beat(8'd2, 1'b1);
    checks++; if (done !== 1'b1 || result !== 8'h38) begin errors++; $display("FAIL rej_result got d%b %h exp d1 38", done, result); end
    checks++; if (errs !== 8'd2 || flips !== 8'd1 || err !== 1'b1) begin errors++; $display("FAIL rej_counts got e%0d f%0d E%b exp e2 f1 E1", errs, flips, err); end
    tick();
  endtask

  task automatic test_cancel_gaps();
    do_load(8'hA5);
    checks++; if (err !== 1'b0 || errs !== 8'd0) begin errors++; $display("FAIL gap_clear got E%b e%0d exp E0 e0", err, errs); end
    beat(8'd3, 1'b0);
    last = 1'b1;
    tick(); tick();
    last = 1'b0;
    checks++; if (result !== 8'hAD || flips !== 8'd1 || ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL gap_hold got %h f%0d r%b d%b exp ad f1 r1 d0", result, flips, ready, done); end
    beat(8'd3, 1'b1);
    checks++; if (done !== 1'b1 || result !== 8'hA5 || flips !== 8'd2) begin errors++; $display("FAIL gap_cancel got d%b %h f%0d exp d1 a5 f2", done, result, flips); end
    tick();
  endtask

  task automatic test_ignored_inputs();
    do_load(8'h11);
    load = 1'b1; data = 8'hFF;
    tick();
    checks++; if (result !== 8'h11 || ready !== 1'b1) begin errors++; $display("FAIL ign_run_load got %h r%b exp 11 r1", result, ready); end
    valid = 1'b1; idx = 8'd0; last = 1'b1;
    tick();
    valid = 1'b0; last = 1'b0;
    checks++; if (done !== 1'b1 || result !== 8'h10) begin errors++; $display("FAIL ign_done got d%b %h exp d1 10", done, result); end
    tick();
    load = 1'b0; data = 8'h00;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h10 || flips !== 8'd1) begin errors++; $display("FAIL ign_done_load got b%b d%b %h f%0d exp b0 d0 10 f1", busy, done, result, flips); end
  endtask

  task automatic test_reset_mid_job();
    do_load(8'h0F);
    beat(8'd4, 1'b0);
    checks++; if (result !== 8'h1F) begin errors++; $display("FAIL mid_pre got %h exp 1f", result); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({ready, busy, done, err} !== 4'b0000 || result !== 8'h00 || flips !== 8'd0 || errs !== 8'd0) begin errors++; $display("FAIL mid_reset got %b %h f%0d e%0d exp 0000 00 f0 e0", {ready, busy, done, err}, result, flips, errs); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_no_done got d%b b%b exp d0 b0", done, busy); end
  endtask

  task automatic test_saturation();
    do_load(8'h00);
    for (int i = 0; i < 5; i++) beat(8'(i), (i == 4));
    checks++; if (s_done !== 1'b1 || s_flips !== 2'd3 || s_result !== 8'h1F) begin errors++; $display("FAIL sat_narrow got d%b f%0d %h exp d1 f3 1f", s_done, s_flips, s_result); end
    checks++; if (flips !== 8'd5 || result !== 8'h1F) begin errors++; $display("FAIL sat_wide got f%0d %h exp f5 1f", flips, result); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_load(8'hF0);
    beat(8'd0, 1'b1);
    tick();
    do_load(8'h0C);
    checks++; if (ready !== 1'b1 || result !== 8'h0C || flips !== 8'd0) begin errors++; $display("FAIL b2b_reload got r%b %h f%0d exp r1 0c f0", ready, result, flips); end
    beat(8'd2, 1'b0);
    beat(8'd3, 1'b1);
    checks++; if (done !== 1'b1 || result !== 8'h00 || flips !== 8'd2) begin errors++; $display("FAIL b2b_result got d%b %h f%0d exp d1 00 f2", done, result, flips); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rejected();
    test_cancel_gaps();
    test_ignored_inputs();
    test_reset_mid_job();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
